// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the CPU memory-port arbiter: access lengths and FSM states.
package mem_bus_arbiter_pkg;

  localparam int MEM_LEN_BITS = 2;
  typedef logic [MEM_LEN_BITS-1:0] mem_len_t;

  localparam mem_len_t MEM_LEN_B = 2'd0;
  localparam mem_len_t MEM_LEN_H = 2'd1;
  localparam mem_len_t MEM_LEN_W = 2'd2;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_WAIT_I = 3'd1,
    ARB_WAIT_D = 3'd2,
    ARB_RESP_I = 3'd3,
    ARB_RESP_D = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/data) arbiter onto a single registered memory bus.
// Data has priority; fetch wins after STARVE_LIMIT data grants taken while it waited.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        flush,
  input  logic        d_req,
  input  logic        d_we,
  input  mem_len_t    d_len,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output mem_len_t    m_len,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             drop;
  logic             starved;

  assign starved = (starve_cnt == CNT_MAX) && i_req;

  // NOTE: i_ack looks at flush combinationally so a redirect arriving in the
  // response cycle itself still suppresses the acknowledge.
  assign i_ack = (state == ARB_RESP_I) && !drop && !flush;
  assign d_ack = (state == ARB_RESP_D);
  assign busy  = (state != ARB_IDLE);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_len      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      drop       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (d_req && !starved) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_len   <= d_len;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            state   <= ARB_WAIT_D;
            if (!i_req)
              starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (i_req && !flush) begin
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_len      <= MEM_LEN_W;
            m_addr     <= i_addr;
            state      <= ARB_WAIT_I;
            starve_cnt <= '0;
          end
        end

        ARB_WAIT_I: begin
          // A flushed fetch still runs to completion on the bus; only its ack is lost.
          if (flush) drop <= 1'b1;
          if (m_ready) begin
            m_req   <= 1'b0;
            i_rdata <= m_rdata;
            state   <= ARB_RESP_I;
          end
        end

        ARB_WAIT_D: begin
          if (m_ready) begin
            m_req   <= 1'b0;
            d_rdata <= m_rdata;
            state   <= ARB_RESP_D;
          end
        end

        ARB_RESP_I: begin
          drop  <= 1'b0;
          state <= ARB_IDLE;
        end

        ARB_RESP_D: state <= ARB_IDLE;

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
